// File: rtl/led_driver_pkg.sv
// Shared definitions for the LED driver register file and its I2C slave front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_driver_pkg;

    localparam int I2C_ADDR_BITS = 7;
    localparam int ADDR_BITS     = 4;
    localparam int DATA_BITS     = 8;

    // Register map of the LED driver.
    localparam logic [ADDR_BITS-1:0] REG_MODE = 4'd0;
    localparam logic [ADDR_BITS-1:0] REG_CTRL = 4'd1;
    localparam logic [ADDR_BITS-1:0] REG_LED0 = 4'd2;
    localparam logic [ADDR_BITS-1:0] REG_LED1 = 4'd3;
    localparam logic [ADDR_BITS-1:0] REG_LED2 = 4'd4;
    localparam logic [ADDR_BITS-1:0] REG_LED3 = 4'd5;
    localparam logic [ADDR_BITS-1:0] REG_LED4 = 4'd6;
    localparam logic [ADDR_BITS-1:0] REG_LED5 = 4'd7;
    localparam logic [ADDR_BITS-1:0] REG_LED6 = 4'd8;
    localparam logic [ADDR_BITS-1:0] REG_LED7 = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        DEV_ADDR,
        REG_PTR,
        WR_DATA,
        RD_FETCH,
        RD_SEND,
        IGNORE
    } i2c_burst_state_t;

    localparam logic I2C_ACK  = 1'b1;
    localparam logic I2C_NACK = 1'b0;

endpackage

// File: rtl/i2c_reg_pointer.sv
// Register pointer with load, increment and auto-increment window wrap.
// Latency: load/inc take effect on the next clk edge; ptr_inc_val is combinational.
// Backpressure: none; load has priority over inc.
// Ports: clk, reset_n (async active-low), load/load_val, inc,
//        ptr (current pointer), ptr_inc_val (value ptr would take on inc).
module i2c_reg_pointer
    import led_driver_pkg::*;
#(
    parameter int NUM_REGS = 10,
    parameter int AUTO_INC = 1,
    parameter int AI_LO    = 0,
    parameter int AI_HI    = NUM_REGS - 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_val,
    input  logic                 inc,
    output logic [ADDR_BITS-1:0] ptr,
    output logic [ADDR_BITS-1:0] ptr_inc_val
);

    localparam logic [ADDR_BITS-1:0] LO_P   = ADDR_BITS'(AI_LO);
    localparam logic [ADDR_BITS-1:0] HI_P   = ADDR_BITS'(AI_HI);
    localparam logic [ADDR_BITS-1:0] LAST_P = ADDR_BITS'(NUM_REGS - 1);

    // The window check comes first so a window ending at the last register
    // wraps to AI_LO rather than to 0.
    always_comb begin
        ptr_inc_val = ptr;
        if (AUTO_INC != 0) begin
            if (ptr == HI_P) begin
                ptr_inc_val = LO_P;
            end else if (ptr == LAST_P) begin
                ptr_inc_val = '0;
            end else begin
                ptr_inc_val = ptr + ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_inc_val;
        end
    end

endmodule

// File: rtl/i2c_burst_controller.sv
// Byte-level I2C slave engine: burst writes, pointer-then-read, per-byte ACK/NACK.
// Latency: ack/reg_we/reg_re one cycle after the byte or tx_req; tx_valid two cycles after.
// Backpressure: none; tx_valid holds until tx_req, stop or start; losing same-cycle events are dropped.
// Ports: clk, reset_n; start/stop/rx_valid/rx_data from the bit receiver;
//        tx_req in, tx_data/tx_valid out to the transmitter; ack_valid/ack per byte;
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata to the register file; busy, transaction_done.
module i2c_burst_controller
    import led_driver_pkg::*;
#(
    parameter logic [I2C_ADDR_BITS-1:0] DEVICE_ADDR = 7'h40,
    parameter int NUM_REGS = 10,
    parameter int AUTO_INC = 1,
    parameter int AI_LO    = 0,
    parameter int AI_HI    = NUM_REGS - 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_req,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 ack_valid,
    output logic                 ack,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [DATA_BITS-1:0] reg_rdata,
    output logic                 busy,
    output logic                 transaction_done
);

    if (ADDR_BITS < $clog2(NUM_REGS) || AI_LO < 0 || AI_LO > AI_HI || AI_HI >= NUM_REGS) begin : g_bad_params
        $error("i2c_burst_controller: illegal NUM_REGS/AI_LO/AI_HI combination");
    end

    i2c_burst_state_t state_q, state_nxt;

    logic [ADDR_BITS-1:0] ptr, ptr_inc_val;
    logic                 ptr_load, ptr_inc;

    logic                 matched_q, matched_nxt;
    logic                 fresh_q, fresh_nxt;
    logic [7:0]           tx_hold_q;
    logic                 ack_vld_nxt, ack_nxt, we_nxt, re_nxt, txv_nxt, done_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic [DATA_BITS-1:0] wdata_nxt;

    i2c_reg_pointer #(
        .NUM_REGS (NUM_REGS),
        .AUTO_INC (AUTO_INC),
        .AI_LO    (AI_LO),
        .AI_HI    (AI_HI)
    ) u_ptr (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (ptr_load),
        .load_val    (rx_data[ADDR_BITS-1:0]),
        .inc         (ptr_inc),
        .ptr         (ptr),
        .ptr_inc_val (ptr_inc_val)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        matched_nxt = matched_q;
        fresh_nxt   = 1'b0;
        ack_vld_nxt = 1'b0;
        ack_nxt     = ack;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        addr_nxt    = reg_addr;
        wdata_nxt   = reg_wdata;
        txv_nxt     = tx_valid;
        done_nxt    = 1'b0;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;

        if (stop) begin
            state_nxt   = IDLE;
            txv_nxt     = 1'b0;
            done_nxt    = matched_q;
            matched_nxt = 1'b0;
        end else if (start) begin
            state_nxt   = DEV_ADDR;
            txv_nxt     = 1'b0;
            matched_nxt = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR: begin
                    if (rx_valid) begin
                        ack_vld_nxt = 1'b1;
                        if (rx_data[7:1] == DEVICE_ADDR) begin
                            ack_nxt     = I2C_ACK;
                            matched_nxt = 1'b1;
                            if (rx_data[0]) begin
                                state_nxt = RD_FETCH;
                                re_nxt    = 1'b1;
                                addr_nxt  = ptr;
                            end else begin
                                state_nxt = REG_PTR;
                            end
                        end else begin
                            ack_nxt   = I2C_NACK;
                            state_nxt = IGNORE;
                        end
                    end
                end
                REG_PTR: begin
                    if (rx_valid) begin
                        ack_vld_nxt = 1'b1;
                        if (int'(rx_data) < NUM_REGS) begin
                            ptr_load  = 1'b1;
                            ack_nxt   = I2C_ACK;
                            state_nxt = WR_DATA;
                        end else begin
                            ack_nxt   = I2C_NACK;
                            state_nxt = IGNORE;
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        ack_vld_nxt = 1'b1;
                        ack_nxt     = I2C_ACK;
                        we_nxt      = 1'b1;
                        addr_nxt    = ptr;
                        wdata_nxt   = rx_data[DATA_BITS-1:0];
                        ptr_inc     = 1'b1;
                    end
                end
                RD_FETCH: begin
                    // reg_re is high this cycle; the data arrives next cycle,
                    // which is when tx_valid rises.
                    state_nxt = RD_SEND;
                    txv_nxt   = 1'b1;
                    fresh_nxt = 1'b1;
                end
                RD_SEND: begin
                    if (tx_req) begin
                        txv_nxt   = 1'b0;
                        ptr_inc   = 1'b1;
                        re_nxt    = 1'b1;
                        addr_nxt  = ptr_inc_val;
                        state_nxt = RD_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matched_q        <= 1'b0;
            fresh_q          <= 1'b0;
            tx_hold_q        <= '0;
            tx_valid         <= 1'b0;
            ack_valid        <= 1'b0;
            ack              <= 1'b0;
            reg_addr         <= '0;
            reg_wdata        <= '0;
            reg_we           <= 1'b0;
            reg_re           <= 1'b0;
            transaction_done <= 1'b0;
        end else begin
            matched_q        <= matched_nxt;
            fresh_q          <= fresh_nxt;
            tx_valid         <= txv_nxt;
            ack_valid        <= ack_vld_nxt;
            ack              <= ack_nxt;
            reg_addr         <= addr_nxt;
            reg_wdata        <= wdata_nxt;
            reg_we           <= we_nxt;
            reg_re           <= re_nxt;
            transaction_done <= done_nxt;
            if (fresh_q) begin
                tx_hold_q <= reg_rdata;
            end
        end
    end

    // In the first RD_SEND cycle the read data is passed straight through and
    // captured; afterwards the captured copy is held until the next fetch.
    assign tx_data = fresh_q ? reg_rdata : tx_hold_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_burst_controller.sv
// Self-checking bench for i2c_burst_controller (AI window 2..5, NUM_REGS 10).
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_burst_controller;

    localparam int NR = 10;
    localparam int LO = 2;
    localparam int HI = 5;
    localparam logic [6:0] DEV = 7'h40;

    localparam int P_IDLE = 0, P_ADDR = 1, P_PTR = 2, P_WR = 3, P_RD = 4, P_IGN = 5;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, rx_valid, tx_req;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_valid, ack_valid, ack, reg_we, reg_re, busy, transaction_done;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    always #5 clk = ~clk;

    i2c_burst_controller #(
        .DEVICE_ADDR (DEV),
        .NUM_REGS    (NR),
        .AUTO_INC    (1),
        .AI_LO       (LO),
        .AI_HI       (HI)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .stop             (stop),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .tx_req           (tx_req),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .ack_valid        (ack_valid),
        .ack              (ack),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_we           (reg_we),
        .reg_re           (reg_re),
        .reg_rdata        (reg_rdata),
        .busy             (busy),
        .transaction_done (transaction_done)
    );

    // Register file: synchronous read, data valid the cycle after reg_re.
    logic       rf_clr;
    logic [7:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
        end else if (reg_we) begin
            rf_mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) reg_rdata <= rf_mem[reg_addr];
    end

    int we_cnt = 0, ackv_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (reg_we === 1'b1)           we_cnt++;
        if (ack_valid === 1'b1)        ackv_cnt++;
        if (transaction_done === 1'b1) done_cnt++;
    end

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int         m_ptr;
    int         m_phase;
    logic       m_matched;
    logic [7:0] ref_mem [16];

    function automatic int nxt(input int p);
        if (p == HI) return LO;
        if (p == NR - 1) return 0;
        return p + 1;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_phase   = P_IDLE;
        m_matched = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        m_phase   = P_ADDR;
        m_matched = 1'b0;
        cmp_cnt++;
        if ({busy, tx_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL start_state: busy/tx_valid got %b want 10", {busy, tx_valid});
        end
    endtask

    task automatic do_stop();
        logic exp_done;
        exp_done = m_matched;
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        cmp_cnt++;
        if ({transaction_done, tx_valid, busy} !== {exp_done, 2'b00}) begin
            err_cnt++;
            $display("FAIL stop: done/tx_valid/busy got %b want %b", {transaction_done, tx_valid, busy}, {exp_done, 2'b00});
        end
        m_phase   = P_IDLE;
        m_matched = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (transaction_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_pulse_width: got %b want 0", transaction_done);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic e_ackv, e_ack, e_we, e_re, rd_trig;
        int   e_addr;
        e_ackv = 0; e_ack = 0; e_we = 0; e_re = 0; rd_trig = 0; e_addr = 0;
        case (m_phase)
            P_ADDR: begin
                e_ackv = 1'b1;
                if (b[7:1] == DEV) begin
                    e_ack = 1'b1;
                    m_matched = 1'b1;
                    if (b[0]) begin
                        e_re = 1'b1; e_addr = m_ptr; rd_trig = 1'b1; m_phase = P_RD;
                    end else begin
                        m_phase = P_PTR;
                    end
                end else begin
                    m_phase = P_IGN;
                end
            end
            P_PTR: begin
                e_ackv = 1'b1;
                if (int'(b) < NR) begin
                    e_ack = 1'b1; m_ptr = int'(b); m_phase = P_WR;
                end else begin
                    m_phase = P_IGN;
                end
            end
            P_WR: begin
                e_ackv = 1'b1; e_ack = 1'b1; e_we = 1'b1; e_addr = m_ptr;
                ref_mem[m_ptr] = b;
                m_ptr = nxt(m_ptr);
            end
            default: ;
        endcase
        @(negedge clk) begin rx_valid = 1'b1; rx_data = b; end
        @(negedge clk) rx_valid = 1'b0;
        cmp_cnt++;
        if ({ack_valid, reg_we, reg_re} !== {e_ackv, e_we, e_re}) begin
            err_cnt++;
            $display("FAIL byte_%h_strobes: ackv/we/re got %b want %b", b, {ack_valid, reg_we, reg_re}, {e_ackv, e_we, e_re});
        end
        if (e_ackv) begin
            cmp_cnt++;
            if (ack !== e_ack) begin
                err_cnt++;
                $display("FAIL byte_%h_ack: got %b want %b", b, ack, e_ack);
            end
        end
        if (e_we || e_re) begin
            cmp_cnt++;
            if (reg_addr !== 4'(e_addr)) begin
                err_cnt++;
                $display("FAIL byte_%h_addr: got %0d want %0d", b, reg_addr, e_addr);
            end
        end
        if (e_we) begin
            cmp_cnt++;
            if (reg_wdata !== b) begin
                err_cnt++;
                $display("FAIL byte_%h_wdata: got %h want %h", b, reg_wdata, b);
            end
        end
        if (rd_trig) begin
            @(negedge clk);
            cmp_cnt++;
            if ({tx_valid, tx_data} !== {1'b1, ref_mem[m_ptr]}) begin
                err_cnt++;
                $display("FAIL first_read: tx_valid/tx_data got %b/%h want 1/%h", tx_valid, tx_data, ref_mem[m_ptr]);
            end
        end
    endtask

    task automatic do_tx_req();
        cmp_cnt++;
        if ({tx_valid, tx_data} !== {1'b1, ref_mem[m_ptr]}) begin
            err_cnt++;
            $display("FAIL tx_hold: tx_valid/tx_data got %b/%h want 1/%h", tx_valid, tx_data, ref_mem[m_ptr]);
        end
        m_ptr = nxt(m_ptr);
        @(negedge clk) tx_req = 1'b1;
        @(negedge clk) tx_req = 1'b0;
        cmp_cnt++;
        if ({tx_valid, reg_re, reg_addr} !== {2'b01, 4'(m_ptr)}) begin
            err_cnt++;
            $display("FAIL tx_req_fetch: tx_valid/re/addr got %b/%b/%0d want 0/1/%0d", tx_valid, reg_re, reg_addr, m_ptr);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({tx_valid, tx_data} !== {1'b1, ref_mem[m_ptr]}) begin
            err_cnt++;
            $display("FAIL tx_next: tx_valid/tx_data got %b/%h want 1/%h", tx_valid, tx_data, ref_mem[m_ptr]);
        end
    endtask

    task automatic check_counts(input string name, input int dwe, input int dack, input int ddone,
                                input int ewe, input int eack, input int edone);
        cmp_cnt++;
        if (dwe !== ewe || dack !== eack || ddone !== edone) begin
            err_cnt++;
            $display("FAIL %s_counts: we/ackv/done got %0d/%0d/%0d want %0d/%0d/%0d", name, dwe, dack, ddone, ewe, eack, edone);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; stop = 0; rx_valid = 0; rx_data = 0; tx_req = 0; rf_clr = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rf_clr = 1'b0;
        cmp_cnt++;
        if ({tx_data, tx_valid, ack_valid, ack, reg_addr, reg_wdata, reg_we, reg_re, busy, transaction_done} !== 27'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h want 0", {tx_data, tx_valid, ack_valid, ack, reg_addr, reg_wdata, reg_we, reg_re, busy, transaction_done});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int w0, a0, d0;
        w0 = we_cnt; a0 = ackv_cnt; d0 = done_cnt;
        do_start();
        send_byte(8'h80); send_byte(8'h01); send_byte(8'hAA);
        do_stop();
        check_counts("single_write", we_cnt - w0, ackv_cnt - a0, done_cnt - d0, 1, 3, 1);
    endtask

    task automatic test_burst_wrap();
        do_start();
        send_byte(8'h80); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        do_stop();
    endtask

    task automatic test_ptr_read();
        do_start();
        send_byte(8'h80); send_byte(8'h07); send_byte(8'h55); send_byte(8'h66);
        do_stop();
        do_start();
        send_byte(8'h80); send_byte(8'h07);
        do_start();
        send_byte(8'h81);
        do_tx_req();
        do_tx_req();
        do_stop();
    endtask

    task automatic test_mismatch();
        int w0, a0, d0;
        w0 = we_cnt; a0 = ackv_cnt; d0 = done_cnt;
        send_byte(8'h80);
        do_start();
        send_byte(8'h82); send_byte(8'h01); send_byte(8'h99);
        do_stop();
        check_counts("mismatch", we_cnt - w0, ackv_cnt - a0, done_cnt - d0, 0, 1, 0);
    endtask

    task automatic test_invalid_ptr();
        int w0, a0, d0;
        w0 = we_cnt; a0 = ackv_cnt; d0 = done_cnt;
        do_start();
        send_byte(8'h80); send_byte(8'h0F); send_byte(8'h12);
        do_stop();
        check_counts("invalid_ptr", we_cnt - w0, ackv_cnt - a0, done_cnt - d0, 0, 2, 1);
        do_start();
        send_byte(8'h81);
        do_stop();
    endtask

    task automatic test_priority();
        do_start();
        send_byte(8'h80); send_byte(8'h05);
        @(negedge clk) begin stop = 1'b1; rx_valid = 1'b1; rx_data = 8'h99; end
        @(negedge clk) begin stop = 1'b0; rx_valid = 1'b0; end
        cmp_cnt++;
        if ({reg_we, ack_valid, transaction_done, busy} !== 4'b0010) begin
            err_cnt++;
            $display("FAIL stop_beats_byte: we/ackv/done/busy got %b want 0010", {reg_we, ack_valid, transaction_done, busy});
        end
        model_reset_phase();
        @(negedge clk) begin start = 1'b1; rx_valid = 1'b1; rx_data = 8'h80; end
        @(negedge clk) begin start = 1'b0; rx_valid = 1'b0; end
        m_phase = P_ADDR;
        cmp_cnt++;
        if ({ack_valid, busy} !== 2'b01) begin
            err_cnt++;
            $display("FAIL start_beats_byte: ackv/busy got %b want 01", {ack_valid, busy});
        end
        send_byte(8'h80); send_byte(8'h06); send_byte(8'h5A);
        do_stop();
    endtask

    task automatic model_reset_phase();
        m_phase   = P_IDLE;
        m_matched = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_start();
        send_byte(8'h80); send_byte(8'h02); send_byte(8'h77);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({tx_data, tx_valid, ack_valid, ack, reg_addr, reg_wdata, reg_we, reg_re, busy, transaction_done} !== 27'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_outputs: got %h want 0", {tx_data, tx_valid, ack_valid, ack, reg_addr, reg_wdata, reg_we, reg_re, busy, transaction_done});
        end
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        do_start();
        send_byte(8'h80); send_byte(8'h03); send_byte(8'h44);
        do_stop();
        // Register 2 was written before the reset and must still read back.
        do_start();
        send_byte(8'h80); send_byte(8'h02);
        do_start();
        send_byte(8'h81);
        do_stop();
    endtask

    task automatic test_random();
        logic [6:0] a;
        int         k;
        for (int n = 0; n < 30; n++) begin
            a = DEV;
            if ($urandom_range(0, 4) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == DEV) a = a ^ 7'h01;
            end
            do_start();
            if ($urandom_range(0, 2) == 0) begin
                send_byte({a, 1'b1});
                if (m_phase == P_RD) begin
                    k = $urandom_range(0, 3);
                    for (int j = 0; j < k; j++) do_tx_req();
                end
            end else begin
                send_byte({a, 1'b0});
                send_byte(8'($urandom_range(0, 12)));
                k = $urandom_range(1, 6);
                for (int j = 0; j < k; j++) send_byte(8'($urandom));
            end
            do_stop();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_ptr_read();
        test_mismatch();
        test_invalid_ptr();
        test_priority();
        test_reset_mid_burst();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_burst_controller.md
# i2c_burst_controller

Byte-level I2C slave transaction engine for the LED driver register file; the parametrised successor of the single-write controller. Consumes START/STOP/byte strobes from the I2C bit-level receiver and adds three things: multi-byte burst writes with a configurable auto-increment window, register reads (including write-pointer-then-repeated-START read), and per-byte ACK/NACK generation. It drives the register file's write strobe and read strobe directly.

## Interface
- DEVICE_ADDR, 7'h40, 7-bit I2C slave address matched against the first byte.
- NUM_REGS, 10, number of implemented registers; pointer values >= NUM_REGS are invalid.
- AUTO_INC, 1, 1 = pointer increments after every data byte; 0 = pointer holds.
- AI_LO, 0, lower bound of the auto-increment window.
- AI_HI, NUM_REGS-1, upper bound of the window; an increment from AI_HI goes to AI_LO.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle START or repeated-START pulse.
- stop  in  1  one-cycle STOP pulse.
- rx_valid  in  1  one-cycle pulse; rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_req  in  1  one-cycle pulse; the master ACKed and wants the next read byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; level signal.
- ack_valid  out  1  one-cycle pulse; ack holds the response to the last byte.
- ack  out  1  1 = ACK, 0 = NACK.
- reg_addr  out  ADDR_BITS  register address for reg_we/reg_re.
- reg_wdata  out  DATA_BITS  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_BITS  register read data; valid the cycle after reg_re.
- busy  out  1  high whenever the state is not IDLE.
- transaction_done  out  1  one-cycle pulse at the STOP of a transaction that addressed this device.

## Operation
- States: IDLE, DEV_ADDR, REG_PTR, WR_DATA, RD_FETCH, RD_SEND, IGNORE.
- start, from any state -> DEV_ADDR. The pointer is retained, so a repeated-START read continues from the pointer set by the preceding write.
- DEV_ADDR, on a byte:
  - rx_data[7:1]==DEVICE_ADDR and rx_data[0]==0: ACK, go to REG_PTR.
  - rx_data[7:1]==DEVICE_ADDR and rx_data[0]==1: ACK, go to RD_FETCH.
  - Address mismatch: NACK, go to IGNORE.
- REG_PTR, on a byte:
  - rx_data < NUM_REGS: pointer <= rx_data[ADDR_BITS-1:0], ACK, go to WR_DATA.
  - Otherwise: NACK, go to IGNORE; the pointer is unchanged.
- WR_DATA, on each byte: reg_we pulse with reg_addr=pointer and reg_wdata=rx_data, ACK, then increment the pointer.
- Increment rule (AUTO_INC=1):
  - pointer==AI_HI -> AI_LO.
  - Otherwise pointer+1, with NUM_REGS-1 wrapping to 0.
  - AUTO_INC=0: the pointer holds.
- RD_FETCH: reg_re pulse with reg_addr=pointer; next cycle tx_data <= reg_rdata, tx_valid=1, go to RD_SEND.
- RD_SEND, on tx_req: tx_valid drops, the pointer increments by the same rule, go to RD_FETCH.
- IGNORE: bytes are dropped, no ack_valid is issued, and no register access occurs.
- Bytes received in RD_SEND are dropped.
- stop, from any state -> IDLE and tx_valid=0. transaction_done pulses if DEV_ADDR was matched since the last START.
- Bytes received in IDLE are ignored.
- Priority within one cycle: stop > start > rx_valid/tx_req. A losing byte or request is discarded.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, pointer 0. All outputs are 0: tx_data, tx_valid, ack_valid, ack, reg_addr, reg_wdata, reg_we, reg_re, busy, transaction_done.
- Reset mid-burst: no further strobes are issued. The writes already issued stand.
- ack_valid/ack are registered: they assert the cycle after rx_valid.
- reg_we asserts the cycle after rx_valid. reg_addr and reg_wdata are stable during that cycle.
- reg_re asserts the cycle after the read-address byte or after tx_req.
- tx_valid rises 2 cycles after the trigger; it stays high until tx_req, stop or start.
- transaction_done asserts the cycle after stop.
- Minimum spacing between rx_valid pulses is 2 cycles.
- ADDR_BITS >= $clog2(NUM_REGS). AI_LO <= AI_HI < NUM_REGS, enforced by an elaboration check.

## Structure
- led_driver_pkg holds:
  - I2C_ADDR_BITS, ADDR_BITS, DATA_BITS and the REG_* addresses.
  - The typedef i2c_burst_state_t (enum of the states above).
  - The constants I2C_ACK=1 and I2C_NACK=0.
- Sub-module i2c_reg_pointer: a pointer register with load, increment, and AUTO_INC/AI_LO/AI_HI wrap logic, parametrised identically to this block.

## Test plan
- Single write: START, 0x80, 0x01, 0xAA, STOP -> one reg_we with addr 0x01, data 0xAA; three ACKs; transaction_done pulses once.
- Burst wrap, with AI_LO=2 and AI_HI=5: START, 0x80, 0x04, then bytes 0x11, 0x22, 0x33 -> writes to 4=0x11, 5=0x22, 2=0x33.
- Pointer then read: START, 0x80, 0x07, repeated START, 0x81, then two tx_req with reg_rdata 0x55 then 0x66 -> reg_re at 7 then 8; tx_data 0x55 then 0x66.
- Address mismatch: START, 0x82, 0x01, 0x99, STOP -> one NACK only, no reg_we, no transaction_done.
- Invalid pointer: START, 0x80, 0x0F (NUM_REGS=10), 0x12 -> NACK on the pointer byte; no write.
- Reset mid-burst: reset_n low after the first data byte -> all outputs 0 immediately; the next START/0x80/0x03/0x44 writes 3=0x44.
